// File: rtl/bq_sched_pkg.sv
// Shared types and helpers for the biquad channel scheduler (bq_chan_sched).
// Build option BQ_SCHED_FIXED_PRIO_EN is consumed by bq_rr_arbiter.
package bq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // Widest channel index the scheduler supports (NCHAN up to 8).
  localparam int MAX_CHW = 3;
  typedef logic [MAX_CHW-1:0] chan_idx_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bq_rr_arbiter.sv
// Request arbiter for bq_chan_sched: round-robin after ptr_i by default,
// fixed lowest-index priority when BQ_SCHED_FIXED_PRIO_EN is defined.
module bq_rr_arbiter
  import bq_sched_pkg::*;
#(
  parameter  int NCHAN = 4,
  localparam int CHW   = clog2(NCHAN)
) (
  input  logic [NCHAN-1:0] req_i,
  input  logic [CHW-1:0]   ptr_i,
  input  logic             en_i,
  output logic [NCHAN-1:0] gnt_o,
  output logic [CHW-1:0]   idx_o,
  output logic             any_o
);

  logic found;

`ifdef BQ_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (!found && req_i[k]) begin
        found = 1'b1;
        idx_o = CHW'(k);
      end
    end
  end
`else
  int cand;

  // Candidates visited in order ptr+1, ptr+2, ... wrapping modulo NCHAN.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int i = 1; i <= NCHAN; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NCHAN) begin
        cand = cand - NCHAN;
      end
      for (int k = 0; k < NCHAN; k++) begin
        if (!found && (k == cand) && req_i[k]) begin
          found = 1'b1;
          idx_o = CHW'(k);
        end
      end
    end
  end
`endif

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < NCHAN; k++) begin
      gnt_o[k] = en_i && found && (idx_o == CHW'(k));
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/bq_chan_sched.sv
// Shares one biquad datapath between NCHAN sample sources; results return
// tagged with their channel. Build option: BQ_SCHED_FIXED_PRIO_EN.
//
// state | meaning
// IDLE  | arbitrate among valid requesters, register the winner
// ISSUE | one-cycle strobe: ready pulse to winner, sample to biquad
// WAIT  | down-count the datapath latency, capture bq_y_i at zero
// DONE  | hold result until res_ready_i
module bq_chan_sched
  import bq_sched_pkg::*;
#(
  parameter  int NCHAN     = 4,
  parameter  int DATAWIDTH = 16,
  parameter  int LATENCY   = 3,
  localparam int CHW       = clog2(NCHAN)
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [NCHAN-1:0]           req_valid_i,
  input  logic [NCHAN*DATAWIDTH-1:0] req_data_i,
  output logic [NCHAN-1:0]           req_ready_o,
  output logic [DATAWIDTH-1:0]       bq_x_o,
  output logic                       bq_valid_o,
  output logic [CHW-1:0]             bq_chan_o,
  input  logic [DATAWIDTH-1:0]       bq_y_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [DATAWIDTH-1:0]       res_data_o,
  output logic [CHW-1:0]             res_chan_o,
  output logic                       busy_o
);

  localparam int              CNTW     = clog2(LATENCY) + 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);

  sched_state_e         state_q;
  logic [CHW-1:0]       g_q;
  logic [CNTW-1:0]      cnt_q;
  logic [DATAWIDTH-1:0] x_q;
  logic [DATAWIDTH-1:0] x_d;
  logic [NCHAN-1:0]     req_ready_q;
  logic                 bq_valid_q;
  logic                 res_valid_q;
  logic [DATAWIDTH-1:0] res_data_q;
  logic [CHW-1:0]       res_chan_q;

  logic [NCHAN-1:0]     arb_gnt;
  logic [CHW-1:0]       arb_idx;
  logic                 arb_any;
  logic [CHW-1:0]       arb_ptr;

`ifdef BQ_SCHED_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [CHW-1:0] ptr_q;

  // Reset value makes channel 0 the first winner.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ptr_q <= CHW'(NCHAN - 1);
    end else if ((state_q == IDLE) && arb_any) begin
      ptr_q <= arb_idx;
    end
  end

  assign arb_ptr = ptr_q;
`endif

  bq_rr_arbiter #(
    .NCHAN (NCHAN)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (arb_ptr),
    .en_i  (state_q == IDLE),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Sample for the granted channel, read live during ISSUE.
  always_comb begin
    x_d = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (g_q == CHW'(k)) begin
        x_d = req_data_i[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      g_q         <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      req_ready_q <= '0;
      bq_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_chan_q  <= '0;
    end else begin
      req_ready_q <= '0;
      bq_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            g_q         <= arb_idx;
            req_ready_q <= arb_gnt;
            bq_valid_q  <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          x_q     <= x_d;
          cnt_q   <= CNT_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            res_data_q  <= bq_y_i;
            res_chan_q  <= g_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outside ISSUE the biquad input keeps the last issued sample.
  assign bq_x_o      = (state_q == ISSUE) ? x_d : x_q;
  assign req_ready_o = req_ready_q;
  assign bq_valid_o  = bq_valid_q;
  assign bq_chan_o   = g_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_chan_o  = res_chan_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_bq_chan_sched.sv
// Scoreboard bench for bq_chan_sched (LATENCY=3 and LATENCY=1 instances).
module tb_bq_chan_sched;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (LATENCY=3)
  logic              rst;
  logic [NCH-1:0]    req_valid, req_ready;
  logic [NCH*DW-1:0] req_data;
  logic [DW-1:0]     bq_x, bq_y, res_data;
  logic              bq_valid, res_valid, res_ready, busy;
  logic [1:0]        bq_chan, res_chan;

  // second instance (LATENCY=1)
  logic              rst1;
  logic [NCH-1:0]    req_valid1, req_ready1;
  logic [NCH*DW-1:0] req_data1;
  logic [DW-1:0]     bq_x1, bq_y1, res_data1;
  logic              bq_valid1, res_valid1, res_ready1, busy1;
  logic [1:0]        bq_chan1, res_chan1;

  bq_chan_sched #(.NCHAN(NCH), .DATAWIDTH(DW), .LATENCY(LAT)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .bq_x_o(bq_x), .bq_valid_o(bq_valid), .bq_chan_o(bq_chan), .bq_y_i(bq_y),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_chan_o(res_chan), .busy_o(busy)
  );

  bq_chan_sched #(.NCHAN(NCH), .DATAWIDTH(DW), .LATENCY(1)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst1),
    .req_valid_i(req_valid1), .req_data_i(req_data1), .req_ready_o(req_ready1),
    .bq_x_o(bq_x1), .bq_valid_o(bq_valid1), .bq_chan_o(bq_chan1), .bq_y_i(bq_y1),
    .res_valid_o(res_valid1), .res_ready_i(res_ready1), .res_data_o(res_data1),
    .res_chan_o(res_chan1), .busy_o(busy1)
  );

  // Biquad stand-in: y = x ^ 0x1888, valid only LAT cycles after the strobe.
  logic [LAT-1:0] pv = '0;
  logic [DW-1:0]  px [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], bq_valid};
    px[0] <= bq_x;
    for (int k = 1; k < LAT; k++) px[k] <= px[k-1];
  end
  assign bq_y = pv[LAT-1] ? (px[LAT-1] ^ 16'h1888) : 16'hDEAD;

  logic          pv1 = 1'b0;
  logic [DW-1:0] px1;
  always @(posedge clk) begin
    pv1 <= bq_valid1;
    px1 <= bq_x1;
  end
  assign bq_y1 = pv1 ? (px1 ^ 16'h1888) : 16'hDEAD;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct packed {logic [1:0] ch; logic [15:0] v;} exp_t;
  exp_t gnt_q[$];
  exp_t res_q[$];
  exp_t gm, rm;

  // hand-computed per-channel samples and their biquad-model results
  logic [15:0] xd [NCH] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
  logic [15:0] yd [NCH] = '{16'h0888, 16'h3888, 16'h2888, 16'h5888};

  // monitor: every issue and every accepted result is checked against the queues
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bq_valid) begin
        if (gnt_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL gnt_unexpected: chan %0d issued, none expected", bq_chan);
        end else begin
          gm = gnt_q.pop_front();
          chk("gnt_chan", bq_chan, gm.ch);
          chk("gnt_ready", req_ready, 32'd1 << gm.ch);
          chk("gnt_x", bq_x, gm.v);
        end
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL res_unexpected: chan %0d data 0x%0h", res_chan, res_data);
        end else begin
          rm = res_q.pop_front();
          chk("res_chan", res_chan, rm.ch);
          chk("res_data", res_data, rm.v);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(output int at);
    at = -1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (bq_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL issue_timeout: no bq_valid_o within 40 cycles");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && res_q.size() != 0; k++) tick(1);
    chk("drain_res_q_empty", res_q.size(), 0);
  endtask

  task automatic push_pair(input int ch);
    gnt_q.push_back('{2'(ch), xd[ch]});
    res_q.push_back('{2'(ch), yd[ch]});
  endtask

  int t, tp;
  int ord2 [6];
  int ord5 [4];

  initial begin
`ifdef BQ_SCHED_FIXED_PRIO_EN
    ord2 = '{0, 0, 0, 0, 0, 0};
    ord5 = '{1, 1, 1, 1};
`else
    ord2 = '{0, 1, 2, 3, 0, 1};
    ord5 = '{3, 1, 3, 1};
`endif
    rst = 1; rst1 = 1;
    req_valid = '0; req_data = '0; res_ready = 0;
    req_valid1 = '0; req_data1 = '0; res_ready1 = 0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_bq_valid", bq_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bq_x", bq_x, 0);
    chk("rst_res_data", res_data, 0);

    // single request on ch2, then hold the result under backpressure
    gnt_q.push_back('{2'd2, 16'h1234});
    res_q.push_back('{2'd2, 16'h0ABC});
    rst = 0;
    req_data[2*DW +: DW] = 16'h1234;
    req_valid = 4'b0100;
    tick(1);
    chk("t1_req_ready", req_ready, 4'b0100);
    chk("t1_bq_valid", bq_valid, 1);
    chk("t1_busy", busy, 1);
    req_valid = '0;
    tick(3);
    chk("t1_no_early_result", res_valid, 0);
    chk("t1_chan_held", bq_chan, 2);
    tick(1);
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_data", res_data, 16'h0ABC);
    chk("t1_res_chan", res_chan, 2);

    req_data[0*DW +: DW] = xd[0];
    req_data[1*DW +: DW] = xd[1];
    req_valid = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, 16'h0ABC);
      chk("hold_res_chan", res_chan, 2);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_bq_valid", bq_valid, 0);
    end
    push_pair(0);
    push_pair(1);
    res_ready = 1;
    tick(1);
    chk("rel_res_valid", res_valid, 0);
    chk("rel_busy", busy, 0);
    chk("rel_req_ready", req_ready, 0);
    tick(1);
    chk("rel_grant_ch0", req_ready, 4'b0001);
    tp = cyc;
    req_valid[0] = 1'b0;
    wait_issue(t);
    chk("rel_second_gap", t - tp, 6);
    req_valid = '0;
    drain();

    // reset during WAIT discards the in-flight ch0 sample and rewinds the pointer
    gnt_q.push_back('{2'd0, xd[0]});
    req_valid = 4'b0001;
    wait_issue(t);
    req_data[3*DW +: DW] = xd[3];
    req_valid = 4'b1011;
    tick(1);
    chk("t4_in_wait_busy", busy, 1);
    rst = 1;
    tick(1);
    chk("t4_busy", busy, 0);
    chk("t4_res_valid", res_valid, 0);
    chk("t4_req_ready", req_ready, 0);
    chk("t4_bq_valid", bq_valid, 0);

    // all channels continuously valid with res_ready_i high
    req_data[2*DW +: DW] = xd[2];
    for (int i = 0; i < 6; i++) push_pair(ord2[i]);
    rst = 0;
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_issue(t);
      if (i == 0) chk("t4_first_grant_ch0", bq_chan, 0);
      else chk("t2_issue_period", t - tp, 6);
      tp = t;
    end
    req_valid = '0;
    drain();

    // ch1 and ch3 continuously valid
    for (int i = 0; i < 4; i++) push_pair(ord5[i]);
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      wait_issue(t);
      if (i > 0) chk("t5_issue_period", t - tp, 6);
      tp = t;
    end
    req_valid = '0;
    drain();

    // LATENCY=1 instance: capture the cycle after the strobe
    chk("l1_rst_res_valid", res_valid1, 0);
    chk("l1_rst_busy", busy1, 0);
    rst1 = 0;
    req_data1[3*DW +: DW] = 16'h0F0F;
    req_valid1 = 4'b1000;
    tick(1);
    chk("l1_bq_valid", bq_valid1, 1);
    chk("l1_req_ready", req_ready1, 4'b1000);
    chk("l1_bq_x", bq_x1, 16'h0F0F);
    chk("l1_bq_chan", bq_chan1, 3);
    req_valid1 = '0;
    tick(1);
    chk("l1_not_yet", res_valid1, 0);
    tick(1);
    chk("l1_res_valid", res_valid1, 1);
    chk("l1_res_data", res_data1, 16'h1787);
    chk("l1_res_chan", res_chan1, 3);
    res_ready1 = 1;
    tick(1);
    chk("l1_released", res_valid1, 0);
    chk("l1_idle", busy1, 0);

    tick(2);
    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
